cam_rd_cntrl: RTL and testbench

CAM_RD_CNTRL -- requirements
Module: cam_rd_cntrl

---
 rtl/cam_pkg.sv | 24 ++
 rtl/msg_desc_fifo.sv | 53 +++++
 rtl/cam_rd_cntrl.sv | 174 +++++++++++++++++
 tb/tb_cam_rd_cntrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default sizing for the CAM message read path.
package cam_pkg;

  localparam int CAM_DATA_WIDTH = 32;
  localparam int CAM_ADDR_WIDTH = 5;
  localparam int CAM_DESC_DEPTH = 4;

  // Descriptor fields are sized for the widest supported CAM; narrower users zero-extend.
  localparam int CAM_MAX_ADDR_WIDTH = 16;

  typedef logic [CAM_MAX_ADDR_WIDTH-1:0] cam_addr_t;

  typedef struct packed {
    cam_addr_t start_addr;
    cam_addr_t end_addr;
  } msg_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/msg_desc_fifo.sv
// Synchronous descriptor FIFO with a fall-through head (desc_o is valid whenever !empty_o).
module msg_desc_fifo
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DESC_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  msg_desc_t desc_i,
  input  logic      pop_i,
  output msg_desc_t desc_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  msg_desc_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign desc_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= desc_i;
  end

endmodule

// File: rtl/cam_rd_cntrl.sv
// Reads queued messages out of the CAM and streams them downstream with sop/eop framing,
// using a 2-entry skid buffer so ready_i can stall without losing in-flight reads.
module cam_rd_cntrl
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int DESC_DEPTH = CAM_DESC_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
  input  logic                  store_start_i,
  input  logic                  store_end_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  input  logic                  ready_i,
  output logic [ADDR_WIDTH-1:0] rd_pointer_o,
  output logic                  busy_o,
  output logic                  overflow_o
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef struct packed {
    addr_t addr;
    logic  sop;
    logic  eop;
  } tag_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    tag_t                  tag;
  } word_t;

  rd_state_t state_q, state_d;
  addr_t     addr_q, addr_d, remain_q, remain_d;
  logic      pend_valid_q, pend_valid_d;
  addr_t     pend_start_q, pend_start_d;
  logic      overflow_q, overflow_d;
  addr_t     rd_pointer_q;
  logic      infl_q;
  tag_t      infl_tag_q, issue_tag;
  word_t     skid_q [2];
  logic      wr_sel_q, rd_sel_q;
  logic [1:0] cnt_q;

  msg_desc_t desc_in, fifo_desc;
  logic      fifo_full, fifo_empty, fifo_pop, desc_push, end_ok, desc_unused;
  addr_t     new_len, head_start, head_len;
  logic      issue, xfer, credit;
  logic [2:0] occupancy;
  word_t     head;

  // A store_end closes the pending message unless store_start wins the same cycle.
  assign end_ok    = store_end_i && !store_start_i && pend_valid_q;
  assign new_len   = end_addr_i - pend_start_q;
  assign desc_push = end_ok && (new_len != '0) && !fifo_full;
  assign overflow_d = overflow_q | (end_ok && (new_len != '0) && fifo_full);
  assign desc_in.start_addr = cam_addr_t'(pend_start_q);
  assign desc_in.end_addr   = cam_addr_t'(end_addr_i);

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_start_d = pend_start_q;
    if (store_start_i) begin
      pend_valid_d = 1'b1;
      pend_start_d = start_addr_i;
    end else if (end_ok) begin
      pend_valid_d = 1'b0;
    end
  end

  msg_desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (desc_push),
    .desc_i  (desc_in),
    .pop_i   (fifo_pop),
    .desc_o  (fifo_desc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign desc_unused = ^fifo_desc;
  assign head_start  = fifo_desc.start_addr[ADDR_WIDTH-1:0];
  assign head_len    = fifo_desc.end_addr[ADDR_WIDTH-1:0] - head_start;

  // Credit counts the word leaving this cycle, so a full pipe still issues one read per cycle.
  assign head      = skid_q[rd_sel_q];
  assign valid_o   = (cnt_q != 2'd0);
  assign xfer      = valid_o && ready_i;
  assign occupancy = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, xfer};
  assign credit    = (occupancy < 3'd2);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    fifo_pop  = 1'b0;
    issue     = 1'b0;
    issue_tag = '{addr: addr_q, sop: 1'b0, eop: 1'b0};
    unique case (state_q)
      IDLE: if (!fifo_empty && credit) begin
        fifo_pop  = 1'b1;
        issue     = 1'b1;
        issue_tag = '{addr: head_start, sop: 1'b1, eop: (head_len == addr_t'(1))};
        addr_d    = head_start + 1'b1;
        remain_d  = head_len - 1'b1;
        state_d   = (head_len == addr_t'(1)) ? DRAIN : READ;
      end
      READ: if (credit) begin
        issue         = 1'b1;
        issue_tag.eop = (remain_q == addr_t'(1));
        addr_d        = addr_q + 1'b1;
        remain_d      = remain_q - 1'b1;
        if (remain_q == addr_t'(1)) state_d = DRAIN;
      end
      DRAIN: if (xfer && head.tag.eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_start_q <= '0;
      overflow_q   <= 1'b0;
      rd_pointer_q <= '0;
      infl_q       <= 1'b0;
      infl_tag_q   <= '0;
      skid_q       <= '{default: '0};
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      cnt_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      pend_valid_q <= pend_valid_d;
      pend_start_q <= pend_start_d;
      overflow_q   <= overflow_d;
      infl_q       <= issue;
      infl_tag_q   <= issue_tag;
      if (infl_q) begin
        skid_q[wr_sel_q] <= '{data: mem_rd_data_i, tag: infl_tag_q};
        wr_sel_q         <= ~wr_sel_q;
      end
      if (xfer) begin
        rd_sel_q     <= ~rd_sel_q;
        rd_pointer_q <= head.tag.addr + 1'b1;
      end
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, xfer};
    end
  end

  assign mem_rd_en_o   = issue;
  assign mem_rd_addr_o = issue ? issue_tag.addr : '0;
  assign data_o        = head.data;
  assign sop_o         = valid_o && head.tag.sop;
  assign eop_o         = valid_o && head.tag.eop;
  assign rd_pointer_o  = rd_pointer_q;
  assign busy_o        = (state_q != IDLE);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_cam_rd_cntrl.sv
// Directed bench for cam_rd_cntrl: table of single messages plus hand-written multi-cycle cases.
module tb_cam_rd_cntrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  start_addr_i = '0;
  logic [4:0]  end_addr_i = '0;
  logic        store_start_i = 1'b0;
  logic        store_end_i = 1'b0;
  logic        mem_rd_en_o;
  logic [4:0]  mem_rd_addr_o;
  logic [31:0] mem_rd_data_i = '0;
  logic [31:0] data_o;
  logic        valid_o, sop_o, eop_o;
  logic        ready_i = 1'b1;
  logic [4:0]  rd_pointer_o;
  logic        busy_o, overflow_o;

  cam_rd_cntrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_addr_i  (start_addr_i),
    .end_addr_i    (end_addr_i),
    .store_start_i (store_start_i),
    .store_end_i   (store_end_i),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .sop_o         (sop_o),
    .eop_o         (eop_o),
    .ready_i       (ready_i),
    .rd_pointer_o  (rd_pointer_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [4:0] a);
    return 32'hC0DE_0000 + 32'(a) * 32'h0000_0101;
  endfunction

  // CAM model: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem_word(mem_rd_addr_o);
  end

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int   cyc = 0;
  bit   busy_seen = 0;
  bit   stall_prev = 0;
  logic [31:0] prev_data;
  logic [1:0]  prev_se;

  always @(posedge clk) cyc++;

  // Monitor: records transfers and checks output stability across stalls.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        check("hold_data", data_o, prev_data);
        check("hold_sop_eop", {30'd0, sop_o, eop_o}, {30'd0, prev_se});
      end
      if (busy_o) busy_seen = 1;
      if (valid_o && ready_i) got_q.push_back('{data_o, sop_o, eop_o, cyc});
      stall_prev = valid_o && !ready_i;
      prev_data  = data_o;
      prev_se    = {sop_o, eop_o};
    end else begin
      stall_prev = 0;
    end
  end

  task automatic add_exp(input logic [4:0] s, input logic [4:0] e);
    logic [4:0] len;
    len = e - s;
    for (int k = 0; k < int'(len); k++)
      exp_q.push_back('{mem_word(s + 5'(k)), (k == 0), (k == int'(len) - 1), 0});
  endtask

  task automatic compare_stream(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_data"}, got_q[i].data, exp_q[i].data);
      check({name, "_sop_eop"}, {30'd0, got_q[i].sop, got_q[i].eop},
            {30'd0, exp_q[i].sop, exp_q[i].eop});
    end
  endtask

  // Inputs change #1 after a rising edge; each pulse lasts one cycle.
  task automatic pulse(input bit ss, input bit se, input logic [4:0] sa, input logic [4:0] ea);
    store_start_i = ss;
    store_end_i   = se;
    start_addr_i  = sa;
    end_addr_i    = ea;
    @(posedge clk); #1;
    store_start_i = 1'b0;
    store_end_i   = 1'b0;
  endtask

  task automatic send_msg(input logic [4:0] s, input logic [4:0] e);
    pulse(1'b1, 1'b0, s, 5'd0);
    pulse(1'b0, 1'b1, 5'd0, e);
  endtask

  task automatic wait_done(input int n, input bit toggle, input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 300; c++) begin
      if (got_q.size() >= n && !busy_o && !valid_o) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
      if (toggle) ready_i = ~ready_i;
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
    ready_i = 1'b1;
  endtask

  typedef struct {
    logic [4:0] s;
    logic [4:0] e;
    bit         toggle;
    int         exp_len;
    logic [4:0] exp_ptr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd3,  5'd7,  1'b0, 4, 5'd7};
    vecs[1] = '{5'd30, 5'd2,  1'b0, 4, 5'd2};
    vecs[2] = '{5'd9,  5'd9,  1'b0, 0, 5'd2};
    vecs[3] = '{5'd12, 5'd13, 1'b0, 1, 5'd13};
    vecs[4] = '{5'd0,  5'd6,  1'b1, 6, 5'd6};

    // Reset state
    #1;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_overflow", {31'd0, overflow_o}, 32'd0);
    check("rst_rd_ptr", {27'd0, rd_pointer_o}, 32'd0);
    check("rst_mem_en", {31'd0, mem_rd_en_o}, 32'd0);
    check("rst_sop_eop", {30'd0, sop_o, eop_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of single messages
    for (int i = 0; i < 5; i++) begin
      got_q.delete();
      exp_q.delete();
      busy_seen = 0;
      ready_i   = 1'b1;
      add_exp(vecs[i].s, vecs[i].e);
      send_msg(vecs[i].s, vecs[i].e);
      if (vecs[i].exp_len > 0) begin
        @(posedge clk); #1;
        check("lat_edge1_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge2_valid", {31'd0, valid_o}, 32'd1);
        wait_done(vecs[i].exp_len, vecs[i].toggle, "vec");
      end else begin
        repeat (6) @(posedge clk);
        #1;
        check("zero_len_busy", {31'd0, busy_seen}, 32'd0);
      end
      compare_stream("vec");
      check("vec_rd_ptr", {27'd0, rd_pointer_o}, {27'd0, vecs[i].exp_ptr});
      check("vec_busy_end", {31'd0, busy_o}, 32'd0);
      if (!vecs[i].toggle)
        for (int k = 1; k < got_q.size(); k++)
          check("b2b_gap", got_q[k].cyc - got_q[k-1].cyc, 32'd1);
    end

    // Pending-start rules: lone end ignored, second start overwrites, start wins a tie
    got_q.delete();
    exp_q.delete();
    busy_seen = 0;
    pulse(1'b0, 1'b1, 5'd0, 5'd5);
    repeat (5) @(posedge clk);
    #1;
    check("end_no_start_busy", {31'd0, busy_seen}, 32'd0);
    check("end_no_start_words", got_q.size(), 32'd0);
    pulse(1'b1, 1'b0, 5'd1, 5'd0);
    pulse(1'b1, 1'b0, 5'd4, 5'd0);
    pulse(1'b0, 1'b1, 5'd0, 5'd6);
    pulse(1'b1, 1'b1, 5'd16, 5'd6);
    pulse(1'b0, 1'b1, 5'd0, 5'd18);
    add_exp(5'd4, 5'd6);
    add_exp(5'd16, 5'd18);
    wait_done(4, 1'b0, "rules");
    compare_stream("rules");
    check("rules_rd_ptr", {27'd0, rd_pointer_o}, 32'd18);

    // Overflow: a stalled blocker message, then 5 more into a 4-deep queue
    got_q.delete();
    exp_q.delete();
    ready_i = 1'b0;
    send_msg(5'd20, 5'd22);
    for (int j = 0; j < 5; j++) begin
      send_msg(5'(2 * j), 5'(2 * j + 2));
      if (j == 3) check("ovf_before_full", {31'd0, overflow_o}, 32'd0);
    end
    check("ovf_set", {31'd0, overflow_o}, 32'd1);
    check("ovf_busy", {31'd0, busy_o}, 32'd1);
    ready_i = 1'b1;
    add_exp(5'd20, 5'd22);
    for (int j = 0; j < 4; j++) add_exp(5'(2 * j), 5'(2 * j + 2));
    wait_done(10, 1'b0, "ovf");
    compare_stream("ovf");
    check("ovf_rd_ptr", {27'd0, rd_pointer_o}, 32'd8);
    check("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // Reset after word 2 of a 5-word message
    got_q.delete();
    exp_q.delete();
    ready_i = 1'b1;
    send_msg(5'd10, 5'd15);
    for (int c = 0; c < 50 && got_q.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    check("mid_rst_words_before", got_q.size(), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_rd_ptr", {27'd0, rd_pointer_o}, 32'd0);
    check("mid_rst_mem_en", {31'd0, mem_rd_en_o}, 32'd0);
    check("mid_rst_sop_eop", {30'd0, sop_o, eop_o}, 32'd0);
    check("mid_rst_data", data_o, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow_o}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_words", got_q.size(), 32'd2);
    if (got_q.size() >= 2) check("post_rst_word2", got_q[1].data, mem_word(5'd11));
    check("post_rst_valid", {31'd0, valid_o}, 32'd0);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    check("post_rst_rd_ptr", {27'd0, rd_pointer_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
